mold_msg_buf: RTL

MOLD_MSG_BUF -- requirements
Module: mold_msg_buf

---
 rtl/mold_msg_buf.sv | 107 ++++++++++
 1 files changed

// File: rtl/mold_msg_buf.sv
// mold_msg_buf: message beat buffer with whole-message space reservation and drop counting
module mold_msg_buf #(
  parameter int AXI_DATA_W = 64,
  parameter int AXI_KEEP_W = 8,
  parameter int ML_W       = 16,
  parameter int DEPTH      = 16,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  nreset,
  input  logic                  mold_msg_v_i,
  input  logic                  mold_msg_start_i,
  input  logic [ML_W-1:0]       mold_msg_len_i,
  input  logic [AXI_KEEP_W-1:0] mold_msg_mask_i,
  input  logic [AXI_DATA_W-1:0] mold_msg_data_i,
  output logic                  itch_v_o,
  input  logic                  itch_ready_i,
  output logic                  itch_start_o,
  output logic                  itch_last_o,
  output logic [ML_W-1:0]       itch_len_o,
  output logic [AXI_KEEP_W-1:0] itch_mask_o,
  output logic [AXI_DATA_W-1:0] itch_data_o,
  output logic [CNT_W-1:0]      drop_cnt_o,
  output logic                  proto_err_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int SH = $clog2(AXI_KEEP_W);
  localparam logic [ML_W-1:0] BB = ML_W'(AXI_KEEP_W);
  typedef enum logic [1:0] {IDLE, ACCEPT, DROP} state_t;
  state_t state, state_nx;
  logic [AW:0] wptr, rptr;
  logic [ML_W-1:0] rem, rem_nx, cur_len, cur_len_nx;
  logic [ML_W:0] beats, free;
  logic wr, pop, last, drop, err;
  logic [AXI_DATA_W-1:0] data_q [DEPTH];
  logic [AXI_KEEP_W-1:0] mask_q [DEPTH];
  logic [ML_W-1:0]       len_q  [DEPTH];
  logic                  start_q [DEPTH];
  logic                  last_q  [DEPTH];
  assign itch_v_o     = wptr != rptr;
  assign pop          = itch_v_o & itch_ready_i;
  assign itch_start_o = start_q[rptr[AW-1:0]];
  assign itch_last_o  = last_q[rptr[AW-1:0]];
  assign itch_len_o   = len_q[rptr[AW-1:0]];
  assign itch_mask_o  = mask_q[rptr[AW-1:0]];
  assign itch_data_o  = data_q[rptr[AW-1:0]];
  // Space check uses occupancy before any same-cycle pop
  assign free  = (ML_W+1)'(DEPTH) - (ML_W+1)'(wptr - rptr);
  assign beats = ({1'b0, mold_msg_len_i} + (ML_W+1)'(AXI_KEEP_W - 1)) >> SH;
  assign last  = mold_msg_start_i ? (mold_msg_len_i <= BB) : (rem <= BB);
  always_comb begin
    state_nx   = state;
    rem_nx     = rem;
    cur_len_nx = cur_len;
    wr         = 1'b0;
    drop       = 1'b0;
    err        = 1'b0;
    if (mold_msg_v_i) begin
      if (mold_msg_start_i) begin
        err        = (state != IDLE) || (mold_msg_len_i == '0);
        cur_len_nx = mold_msg_len_i;
        rem_nx     = mold_msg_len_i > BB ? mold_msg_len_i - BB : '0;
        if (mold_msg_len_i == '0) state_nx = IDLE;
        else if (beats <= free) begin
          wr       = 1'b1;
          state_nx = last ? IDLE : ACCEPT;
        end else begin
          drop     = 1'b1;
          state_nx = last ? IDLE : DROP;
        end
      end else if (state == IDLE) err = 1'b1;
      else begin
        wr       = state == ACCEPT;
        rem_nx   = rem > BB ? rem - BB : '0;
        state_nx = last ? IDLE : state;
      end
    end
  end
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state       <= IDLE;
      wptr        <= '0;
      rptr        <= '0;
      rem         <= '0;
      cur_len     <= '0;
      drop_cnt_o  <= '0;
      proto_err_o <= 1'b0;
    end else begin
      state       <= state_nx;
      rem         <= rem_nx;
      cur_len     <= cur_len_nx;
      wptr        <= wptr + (AW+1)'(wr);
      rptr        <= rptr + (AW+1)'(pop);
      proto_err_o <= proto_err_o | err;
      if (drop && !(&drop_cnt_o)) drop_cnt_o <= drop_cnt_o + CNT_W'(1);
    end
  end
  always_ff @(posedge clk) begin
    if (wr) begin
      data_q[wptr[AW-1:0]]  <= mold_msg_data_i;
      mask_q[wptr[AW-1:0]]  <= mold_msg_mask_i;
      len_q[wptr[AW-1:0]]   <= mold_msg_start_i ? mold_msg_len_i : cur_len;
      start_q[wptr[AW-1:0]] <= mold_msg_start_i;
      last_q[wptr[AW-1:0]]  <= last;
    end
  end
endmodule
